// File: rtl/mips32_mem_arbiter.sv
// Fixed-priority (ld > dm > if) arbiter sharing one synchronous 1024x32 memory.
// Define MIPS32_ARB_STARVE_GUARD_EN to force a fetch grant after STARVE_MAX denials.
module mips32_mem_arbiter #(
    parameter int AW         = 10,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk1,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic          dm_rvalid,
    output logic [DW-1:0] dm_rdata,
    input  logic          ld_req,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    output logic          ld_gnt,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [2:0]    starve_cnt
);

    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} owner_e;

    owner_e        owner_q, owner_d;
    logic [2:0]    starve_q, starve_d;
    logic [DW-1:0] if_rdata_q, dm_rdata_q;
    logic          fetch_force;

`ifdef MIPS32_ARB_STARVE_GUARD_EN
    assign fetch_force = if_req && (starve_q == 3'(STARVE_MAX));
`else
    assign fetch_force = 1'b0;
`endif

    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        ld_gnt    = 1'b0;
        dm_gnt    = 1'b0;
        if_gnt    = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        owner_d   = OWN_NONE;
        starve_d  = starve_q;

        if (rst_n) begin
            if (fetch_force)  if_gnt = 1'b1;
            else if (ld_req)  ld_gnt = 1'b1;
            else if (dm_req)  dm_gnt = 1'b1;
            else if (if_req)  if_gnt = 1'b1;
        end

        if (ld_gnt) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = ld_addr;
            mem_wdata = ld_wdata;
        end else if (dm_gnt) begin
            mem_en    = 1'b1;
            mem_we    = dm_we;
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
            owner_d   = dm_we ? OWN_NONE : OWN_DM;
        end else if (if_gnt) begin
            mem_en    = 1'b1;
            mem_addr  = if_addr;
            owner_d   = OWN_IF;
        end

        // Debug counter tracks consecutive denied fetch cycles, saturating.
        if (!if_req || if_gnt)
            starve_d = '0;
        else if (starve_q < 3'(STARVE_MAX))
            starve_d = starve_q + 3'd1;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            owner_q    <= OWN_NONE;
            starve_q   <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            owner_q  <= owner_d;
            starve_q <= starve_d;
            if (owner_q == OWN_IF) if_rdata_q <= mem_rdata;
            if (owner_q == OWN_DM) dm_rdata_q <= mem_rdata;
        end
    end

    // Response appears combinationally from memory; non-owners show their last data.
    assign if_rvalid  = rst_n && (owner_q == OWN_IF);
    assign dm_rvalid  = rst_n && (owner_q == OWN_DM);
    assign if_rdata   = !rst_n ? '0 : (if_rvalid ? mem_rdata : if_rdata_q);
    assign dm_rdata   = !rst_n ? '0 : (dm_rvalid ? mem_rdata : dm_rdata_q);
    assign starve_cnt = starve_q;

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Self-checking bench for mips32_mem_arbiter: directed corner sequences, a grant
// vector table and a randomized run against a transaction-level reference model.
module tb_mips32_mem_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int STARVE_MAX = 4;
`ifdef MIPS32_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          clk1 = 1'b0;
    logic          rst_n;
    logic          if_req, dm_req, dm_we, ld_req;
    logic [AW-1:0] if_addr, dm_addr, ld_addr;
    logic [DW-1:0] dm_wdata, ld_wdata;
    logic          if_gnt, dm_gnt, ld_gnt, if_rvalid, dm_rvalid;
    logic [DW-1:0] if_rdata, dm_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [2:0]    starve_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk1 = ~clk1;

    mips32_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX)) dut (
        .clk1(clk1), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(ld_gnt),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .starve_cnt(starve_cnt)
    );

    function automatic logic [DW-1:0] init_val(input int a);
        return 32'hC0DE0000 | 32'(a);
    endfunction

    // Synchronous single-port memory: writes land at the edge, reads return next cycle.
    logic [DW-1:0] tb_mem [1024];
    initial for (int i = 0; i < 1024; i++) tb_mem[i] = init_val(i);
    always @(posedge clk1) begin
        if (mem_en) begin
            if (mem_we) tb_mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= tb_mem[mem_addr];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc_end();
        @(posedge clk1);
        #1;
    endtask

    task automatic idle();
        ld_req = 0; dm_req = 0; if_req = 0; dm_we = 0;
    endtask

    typedef struct {
        bit ld, dm, we, fi;
        bit g_ld, g_dm, g_if, en, mwe;
        bit rv_if, rv_dm;
    } vec_t;
    vec_t vecs [10];

    typedef struct {
        bit            act;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } rq_t;

    rq_t           ld_r, dm_r, if_r;
    logic [DW-1:0] mm [1024];
    logic [DW-1:0] pend_data, last_if, last_dm;
    int            pend_who, scnt, win;
    bit            force_if;
    logic [2:0]    exp_gnt;

    initial begin
        //                ld dm we if  gl gd gi en we  rvi rvd
        vecs[0] = '{0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0};
        vecs[1] = '{0, 0, 0, 1,  0, 0, 1, 1, 0,  1, 0};
        vecs[2] = '{0, 1, 0, 0,  0, 1, 0, 1, 0,  0, 1};
        vecs[3] = '{0, 1, 1, 0,  0, 1, 0, 1, 1,  0, 0};
        vecs[4] = '{1, 0, 0, 0,  1, 0, 0, 1, 1,  0, 0};
        vecs[5] = '{1, 1, 0, 1,  1, 0, 0, 1, 1,  0, 0};
        vecs[6] = '{0, 1, 0, 1,  0, 1, 0, 1, 0,  0, 1};
        vecs[7] = '{0, 1, 1, 1,  0, 1, 0, 1, 1,  0, 0};
        vecs[8] = '{1, 1, 1, 1,  1, 0, 0, 1, 1,  0, 0};
        vecs[9] = '{1, 0, 0, 1,  1, 0, 0, 1, 1,  0, 0};

        // Reset with every requester asserted.
        rst_n = 0; ld_req = 1; dm_req = 1; if_req = 1; dm_we = 0;
        ld_addr = 3; dm_addr = 4; if_addr = 6; ld_wdata = 32'h1; dm_wdata = 32'h2;
        repeat (3) @(posedge clk1);
        @(negedge clk1);
        check("rst_gnt", 64'({ld_gnt, dm_gnt, if_gnt}), 64'd0);
        check("rst_mem", 64'({mem_en, mem_we}), 64'd0);
        check("rst_mem_addr_wdata", 64'({mem_addr, mem_wdata}), 64'd0);
        check("rst_rvalid", 64'({if_rvalid, dm_rvalid}), 64'd0);
        check("rst_rdata", 64'({if_rdata, dm_rdata}), 64'd0);
        check("rst_starve", 64'(starve_cnt), 64'd0);
        rst_n = 1; idle();
        cyc_end();

        // Loader write then fetch of the same word.
        ld_req = 1; ld_addr = 5; ld_wdata = 32'h2800000A;
        @(negedge clk1);
        check("ldf_gnt", 64'({ld_gnt, dm_gnt, if_gnt}), 64'b100);
        check("ldf_mem", 64'({mem_en, mem_we, mem_addr, mem_wdata}), {30'd0, 2'b11, 10'd5, 32'h2800000A});
        cyc_end();
        ld_req = 0; if_req = 1; if_addr = 5;
        @(negedge clk1);
        check("ldf_if_gnt", 64'({if_gnt, mem_en, mem_we, mem_addr}), {51'd0, 3'b110, 10'd5});
        cyc_end();
        if_req = 0;
        @(negedge clk1);
        check("ldf_if_rvalid", 64'({if_rvalid, dm_rvalid}), 64'b10);
        check("ldf_if_rdata", 64'(if_rdata), 64'h2800000A);
        cyc_end();

        // Three-way contention.
        ld_req = 1; ld_addr = 30; ld_wdata = 32'h11112222;
        dm_req = 1; dm_we = 0; dm_addr = 7;
        if_req = 1; if_addr = 30;
        @(negedge clk1);
        check("cont_c0_gnt", 64'({ld_gnt, dm_gnt, if_gnt}), 64'b100);
        cyc_end();
        ld_req = 0;
        @(negedge clk1);
        check("cont_c1_gnt", 64'({ld_gnt, dm_gnt, if_gnt}), 64'b010);
        cyc_end();
        dm_req = 0;
        @(negedge clk1);
        check("cont_c2_gnt", 64'({ld_gnt, dm_gnt, if_gnt}), 64'b001);
        check("cont_c2_rvalid", 64'({if_rvalid, dm_rvalid}), 64'b01);
        check("cont_c2_dm_rdata", 64'(dm_rdata), 64'(init_val(7)));
        cyc_end();
        if_req = 0;
        @(negedge clk1);
        check("cont_c3_rvalid", 64'({if_rvalid, dm_rvalid}), 64'b10);
        check("cont_c3_if_rdata", 64'(if_rdata), 64'h11112222);
        check("cont_c3_dm_hold", 64'(dm_rdata), 64'(init_val(7)));
        cyc_end();

        // Store followed immediately by load of the same address.
        dm_req = 1; dm_we = 1; dm_addr = 12; dm_wdata = 32'h55;
        @(negedge clk1);
        check("st_gnt", 64'({dm_gnt, mem_we, mem_addr, mem_wdata}), {21'd0, 2'b11, 10'd12, 32'h55});
        cyc_end();
        dm_we = 0;
        @(negedge clk1);
        check("ld_after_st_gnt", 64'({dm_gnt, mem_we}), 64'b10);
        check("st_no_rvalid", 64'(dm_rvalid), 64'd0);
        cyc_end();
        idle();
        @(negedge clk1);
        check("ld_after_st_rvalid", 64'(dm_rvalid), 64'd1);
        check("ld_after_st_rdata", 64'(dm_rdata), 64'h55);
        cyc_end();

        // Grant table; each vector is followed by an idle cycle to observe rvalid.
        for (int i = 0; i < 10; i++) begin
            ld_req = vecs[i].ld; dm_req = vecs[i].dm; dm_we = vecs[i].we; if_req = vecs[i].fi;
            ld_addr = 10'(100 + i); dm_addr = 10'(200 + i); if_addr = 10'(300 + i);
            ld_wdata = 32'(i) + 32'hAB00; dm_wdata = 32'(i) + 32'hCD00;
            @(negedge clk1);
            check($sformatf("vec%0d_gnt", i), 64'({ld_gnt, dm_gnt, if_gnt}),
                  64'({vecs[i].g_ld, vecs[i].g_dm, vecs[i].g_if}));
            check($sformatf("vec%0d_mem", i), 64'({mem_en, mem_we}), 64'({vecs[i].en, vecs[i].mwe}));
            cyc_end();
            idle();
            @(negedge clk1);
            check($sformatf("vec%0d_rvalid", i), 64'({if_rvalid, dm_rvalid}),
                  64'({vecs[i].rv_if, vecs[i].rv_dm}));
            cyc_end();
        end

        // Fetch starvation under a continuous data-load stream.
        scnt = 0;
        dm_req = 1; dm_we = 0; dm_addr = 40; if_req = 1; if_addr = 41;
        for (int k = 0; k < 8; k++) begin
            force_if = GUARD && (scnt == STARVE_MAX);
            @(negedge clk1);
            check($sformatf("starve_k%0d_cnt", k), 64'(starve_cnt), 64'(scnt));
            check($sformatf("starve_k%0d_gnt", k), 64'({dm_gnt, if_gnt}), 64'({!force_if, force_if}));
            if (force_if) scnt = 0;
            else if (scnt < STARVE_MAX) scnt++;
            cyc_end();
        end
        idle();
        cyc_end();

        // Reset arriving the cycle after a fetch grant.
        if_req = 1; if_addr = 50;
        @(negedge clk1);
        check("rstrd_gnt", 64'(if_gnt), 64'd1);
        cyc_end();
        rst_n = 0; if_req = 0;
        @(negedge clk1);
        check("rstrd_dropped", 64'(if_rvalid), 64'd0);
        cyc_end();
        rst_n = 1;
        @(negedge clk1);
        check("rstrd_owner_clear", 64'({if_rvalid, dm_rvalid}), 64'd0);
        cyc_end();
        if_req = 1;
        @(negedge clk1);
        check("rstrd_refetch_gnt", 64'(if_gnt), 64'd1);
        cyc_end();
        if_req = 0;
        @(negedge clk1);
        check("rstrd_refetch_rvalid", 64'(if_rvalid), 64'd1);
        check("rstrd_refetch_rdata", 64'(if_rdata), 64'(init_val(50)));
        cyc_end();

        // Randomized traffic against a transaction-level model.
        for (int i = 0; i < 1024; i++) mm[i] = init_val(i);
        last_if = init_val(50); last_dm = '0;
        pend_who = 0; pend_data = '0; scnt = 0;
        ld_r = '{0, 1, '0, '0}; dm_r = '{0, 0, '0, '0}; if_r = '{0, 0, '0, '0};
        for (int c = 0; c < 600; c++) begin
            if (!ld_r.act && $urandom_range(0, 5) == 0)
                ld_r = '{1, 1, 10'(1008 + $urandom_range(0, 15)), $urandom};
            if (!dm_r.act && $urandom_range(0, 9) < 7)
                dm_r = '{1, 1'($urandom_range(0, 1)), 10'(1008 + $urandom_range(0, 15)), $urandom};
            if (!if_r.act && $urandom_range(0, 9) < 6)
                if_r = '{1, 0, 10'(1008 + $urandom_range(0, 15)), '0};
            ld_req = ld_r.act; ld_addr = ld_r.addr; ld_wdata = ld_r.data;
            dm_req = dm_r.act; dm_we = dm_r.we; dm_addr = dm_r.addr; dm_wdata = dm_r.data;
            if_req = if_r.act; if_addr = if_r.addr;

            force_if = GUARD && if_r.act && (scnt == STARVE_MAX);
            if (force_if)       win = 3;
            else if (ld_r.act)  win = 1;
            else if (dm_r.act)  win = 2;
            else if (if_r.act)  win = 3;
            else                win = 0;
            exp_gnt = {win == 1, win == 2, win == 3};

            @(negedge clk1);
            check("rnd_gnt", 64'({ld_gnt, dm_gnt, if_gnt}), 64'(exp_gnt));
            check("rnd_mem_en", 64'(mem_en), 64'(win != 0));
            check("rnd_starve", 64'(starve_cnt), 64'(scnt));
            check("rnd_rvalid", 64'({if_rvalid, dm_rvalid}), 64'({pend_who == 1, pend_who == 2}));
            if (pend_who == 1) last_if = pend_data;
            if (pend_who == 2) last_dm = pend_data;
            check("rnd_if_rdata", 64'(if_rdata), 64'(last_if));
            check("rnd_dm_rdata", 64'(dm_rdata), 64'(last_dm));

            pend_who = 0;
            case (win)
                1: begin
                    check("rnd_ld_mem", 64'({mem_we, mem_addr, mem_wdata}), 64'({1'b1, ld_r.addr, ld_r.data}));
                    mm[ld_r.addr] = ld_r.data;
                    ld_r.act = 0;
                end
                2: begin
                    check("rnd_dm_mem", 64'({mem_we, mem_addr}), 64'({dm_r.we, dm_r.addr}));
                    if (dm_r.we) begin
                        check("rnd_dm_wdata", 64'(mem_wdata), 64'(dm_r.data));
                        mm[dm_r.addr] = dm_r.data;
                    end else begin
                        pend_who = 2; pend_data = mm[dm_r.addr];
                    end
                    dm_r.act = 0;
                end
                3: begin
                    check("rnd_if_mem", 64'({mem_we, mem_addr}), 64'({1'b0, if_r.addr}));
                    pend_who = 1; pend_data = mm[if_r.addr];
                    if_r.act = 0;
                end
                default: ;
            endcase
            if (!if_req || win == 3) scnt = 0;
            else if (scnt < STARVE_MAX) scnt++;
            cyc_end();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
